mult_seq_driver: RTL and testbench
==================================

Name: mult_seq_driver

Overview:
- Host-side requester for the sequential 8x8 multiplier. It sits on the opposite end of the start/done interface from mult_control.
- Accepts operand pairs over a valid/ready handshake, presents them to the multiplier datapath and issues a single-cycle start pulse.
- Waits for done, captures the 16-bit product and returns it over a valid/ready result handshake.
- Guards against a hung multiplier with a timeout and flags protocol violations.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles from start pulse to done before error; legal range 6..255.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_a  in  1  synchronous, active-high reset
- op_valid  in  1  operand pair valid
- op_ready  out  1  driver can accept operands
- op_a  in  8  multiplicand
- op_b  in  8  multiplier
- dataa  out  8  operand A to multiplier datapath; held stable while busy
- datab  out  8  operand B to multiplier datapath; held stable while busy
- start  out  1  to mult_control; exactly one-cycle pulse per operation
- done  in  1  from mult_control
- product  in  16  multiplier datapath result; valid when done=1
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- result  out  16  captured product (0x0000 on error)
- res_err  out  1  qualifies result: 1 = timeout
- busy  out  1  1 in any state except IDLE
- proto_err  out  1  sticky: done seen outside WAIT; cleared only by reset

Behaviour:
- Reset (synchronous, reset_a=1 at clk edge): state=IDLE; op_ready=1; start=0; res_valid=0; res_err=0; result=0; dataa=datab=0; busy=0; proto_err=0; timeout counter=0. Reset overrides everything, including mid-WAIT: start drops and the transaction is discarded.
- States: IDLE, LAUNCH, WAIT, GAP, HOLD.
- IDLE:
  - op_ready=1.
  - On op_valid&op_ready, register op_a→dataa and op_b→datab, then go to LAUNCH.
- LAUNCH:
  - start=1 for this cycle only; counter cleared; go to WAIT.
  - start is never high two consecutive cycles (mult_control would enter ERR).
- WAIT:
  - start=0; counter increments each cycle.
  - If done=1: result<=product, res_err<=0, go to GAP.
  - Else if counter==TIMEOUT_CYCLES-1: result<=0, res_err<=1, go to GAP.
  - done and timeout in the same cycle: done wins.
- GAP:
  - One idle cycle so mult_control returns to IDLE with start low; go to HOLD.
- HOLD:
  - res_valid=1; result and res_err stable.
  - On res_ready, res_valid drops next cycle and state goes to IDLE.
  - res_ready held low: stay in HOLD indefinitely.
- Latency:
  - Operand accept at cycle N → start high at N+1.
  - done at cycle M → res_valid high at M+2.
- dataa/datab stay unchanged from LAUNCH through HOLD exit.
- op_ready=0 in all states but IDLE; no operand buffering.
- done=1 in any state other than WAIT: ignored for data, but sets proto_err.
- Counter saturates; no wrap while in WAIT.
- Throughput: one operation per (multiplier latency + 4) cycles minimum with res_ready tied high.

Decomposition:
- Shared package mult_pkg holds:
  - state enum for the driver: IDLE, LAUNCH, WAIT, GAP, HOLD.
  - operand width 8 and product width 16 constants.
  - default TIMEOUT_CYCLES.
- One natural sub-module: mult_timeout_cnt. Clear/enable/saturating counter with a terminal-count compare; ports clk, reset_a, clr, en, tc.
- FSM and datapath registers stay in mult_seq_driver.

Test Plan:
- Basic: op_a=0x0F, op_b=0x0A, behavioural multiplier returns done 5 cycles after start with product=0x0096 → start is a single pulse 1 cycle after accept; res_valid 2 cycles after done; result=0x0096, res_err=0.
- Max operands: 0xFF×0xFF, res_ready high → result=0xFE01; dataa/datab remain 0xFF throughout WAIT.
- Backpressure: res_ready low for 3 cycles in HOLD → res_valid and result stable all 3 cycles; op_ready=0; returns to IDLE one cycle after res_ready=1.
- Timeout: model never asserts done, TIMEOUT_CYCLES=16 → res_valid with res_err=1 and result=0x0000 exactly 18 cycles after start; start pulses once only.
- Reset mid-operation: reset_a=1 in the 2nd WAIT cycle → next edge IDLE, op_ready=1, start=0, res_valid=0. A subsequent 0x03×0x04 yields 0x000C.
- Protocol/back-to-back: spurious done pulse in IDLE → proto_err=1 and sticky, no res_valid. Then two queued operand pairs with op_valid held high → two distinct start pulses separated by ≥ GAP+HOLD, results in order.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 8x8 multiplier host-side driver:
// datapath widths, default timeout settings and the driver state encoding.
package mult_pkg;

    // Datapath widths of the multiplier interface.
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    // Default timeout: cycles allowed from the start pulse until done.
    localparam int DEF_TIMEOUT_CYCLES = 16;
    localparam int DEF_CNT_W          = 8;

    // Driver FSM state encoding. Plain constants keep the encoding stable
    // for older tools and for checkers that bind on the raw state value.
    typedef logic [2:0] drv_state_t;

    localparam drv_state_t ST_IDLE   = 3'd0;
    localparam drv_state_t ST_LAUNCH = 3'd1;
    localparam drv_state_t ST_WAIT   = 3'd2;
    localparam drv_state_t ST_GAP    = 3'd3;
    localparam drv_state_t ST_HOLD   = 3'd4;

    // Value the timeout counter must reach to declare a hung multiplier.
    // The counter starts at zero in the first WAIT cycle, so the last
    // permitted WAIT cycle sees TIMEOUT_CYCLES-1.
    function automatic int timeout_tc(input int timeout_cycles);
        return timeout_cycles - 1;
    endfunction

endpackage : mult_pkg

// File: rtl/mult_timeout_cnt.sv
// Clear/enable counter that saturates at its terminal count. Used by the
// driver to bound how long it waits for done from the multiplier.
module mult_timeout_cnt #(
    parameter int CNT_W    = 8,
    parameter int TC_VALUE = 15
) (
    input  logic clk,
    input  logic reset_a,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_CNT = CNT_W'(TC_VALUE);

    logic [CNT_W-1:0] cnt;

    // Count while enabled; clear has priority; hold at terminal count so the
    // value never wraps back into the legal waiting range.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TC_CNT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal-count flag, valid in the same cycle the count is reached.
    always_comb begin
        tc = (cnt == TC_CNT);
    end

endmodule : mult_timeout_cnt

// File: rtl/mult_seq_driver.sv
// Host-side requester for the sequential 8x8 multiplier. Accepts an operand
// pair, drives it onto the multiplier datapath, issues a one-cycle start
// pulse, waits for done (bounded by a timeout), and returns the product.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. op_ready is 1 only in IDLE (no operand buffering). res_valid
// is 1 only in HOLD, and result/res_err stay constant until the transfer.
module mult_seq_driver
    import mult_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_a,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    output logic [OP_W-1:0]   dataa,
    output logic [OP_W-1:0]   datab,
    output logic              start,
    input  logic              done,
    input  logic [PROD_W-1:0] product,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PROD_W-1:0] result,
    output logic              res_err,
    output logic              busy,
    output logic              proto_err
);

    drv_state_t state;
    drv_state_t state_next;

    logic accept;
    logic cnt_clr;
    logic cnt_en;
    logic tc;

    // Timeout counter: cleared in LAUNCH, counts every WAIT cycle.
    mult_timeout_cnt #(
        .CNT_W    (CNT_W),
        .TC_VALUE (timeout_tc(TIMEOUT_CYCLES))
    ) u_timeout_cnt (
        .clk     (clk),
        .reset_a (reset_a),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .tc      (tc)
    );

    // Moore outputs decoded from the registered state, so start can never
    // stay high for two cycles and reset removes it at the next edge.
    always_comb begin
        op_ready  = (state == ST_IDLE);
        start     = (state == ST_LAUNCH);
        res_valid = (state == ST_HOLD);
        busy      = (state != ST_IDLE);
        accept    = op_valid && (state == ST_IDLE);
        cnt_clr   = (state == ST_LAUNCH);
        cnt_en    = (state == ST_WAIT);
    end

    // Next-state logic; done beats timeout when both occur together.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT:   if (done || tc) state_next = ST_GAP;
            ST_GAP:    state_next = ST_HOLD;
            ST_HOLD:   if (res_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand registers: loaded only on accept, so they stay stable from
    // LAUNCH until the result has been taken.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            dataa <= '0;
            datab <= '0;
        end else if (accept) begin
            dataa <= op_a;
            datab <= op_b;
        end
    end

    // Result capture at the end of WAIT: product on done, zero with the
    // error flag on timeout.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            result  <= '0;
            res_err <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (done) begin
                result  <= product;
                res_err <= 1'b0;
            end else if (tc) begin
                result  <= '0;
                res_err <= 1'b1;
            end
        end
    end

    // Sticky protocol error: done is only legal while waiting for it.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            proto_err <= 1'b0;
        end else if (done && (state != ST_WAIT)) begin
            proto_err <= 1'b1;
        end
    end

endmodule : mult_seq_driver

// File: tb/tb_mult_seq_driver.sv
// Self-checking bench for mult_seq_driver with a behavioural multiplier
// model on the start/done side and a queue-based result scoreboard.
module tb_mult_seq_driver;
  import mult_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic        start;
  logic        done;
  logic [15:0] product;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        res_err;
  logic        busy;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];   // {res_err, result}

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mult_seq_driver #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset_a(reset_a), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .dataa(dataa), .datab(datab), .start(start),
    .done(done), .product(product), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .res_err(res_err), .busy(busy), .proto_err(proto_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural multiplier ----------------
  int          mult_lat   = 5;
  logic        never_done = 1'b0;
  logic        force_done = 1'b0;
  logic        model_done = 1'b0;
  logic        m_busy     = 1'b0;
  int          m_cnt      = 0;
  logic [15:0] m_prod     = 16'h0;

  assign done    = model_done | force_done;
  assign product = m_prod;

  always @(posedge clk) begin
    if (reset_a) begin
      m_busy     <= 1'b0;
      m_cnt      <= 0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
        m_prod <= {8'h00, dataa} * {8'h00, datab};
      end else if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == mult_lat - 1) begin
          model_done <= ~never_done;
          m_busy     <= 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          acc_cyc   = -100;
  int          start_cyc = -100;
  int          done_cyc  = -100;
  logic        got_done  = 1'b0;
  logic        track     = 1'b0;
  logic        b2b_phase = 1'b0;
  logic        b2b_seen  = 1'b0;
  logic [7:0]  acc_a = 8'h0, acc_b = 8'h0, cap_a = 8'h0, cap_b = 8'h0;
  logic        prev_start = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0, prev_hs = 1'b0;
  logic [15:0] prev_res = 16'h0;
  logic        prev_err = 1'b0;
  logic [16:0] exp_v;

  always @(negedge clk) begin
    if (reset_a) begin
      track = 1'b0; got_done = 1'b0; b2b_seen = 1'b0;
      prev_start = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0; prev_hs = 1'b0;
    end else begin
      if (op_valid && op_ready) begin
        acc_cyc = cyc; acc_a = op_a; acc_b = op_b;
      end
      if (start) begin
        chk("start_latency", cyc, acc_cyc + 1);
        chk("start_single", {31'd0, prev_start}, 0);
        chk("launch_dataa", {24'd0, dataa}, {24'd0, acc_a});
        chk("launch_datab", {24'd0, datab}, {24'd0, acc_b});
        if (b2b_phase && b2b_seen) chk("b2b_start_gap", cyc - start_cyc, mult_lat + 4);
        if (b2b_phase) b2b_seen = 1'b1;
        cap_a = dataa; cap_b = datab; track = 1'b1; start_cyc = cyc; got_done = 1'b0;
      end else if (track && busy) begin
        chk("stable_dataa", {24'd0, dataa}, {24'd0, cap_a});
        chk("stable_datab", {24'd0, datab}, {24'd0, cap_b});
      end
      if (!busy) track = 1'b0;
      if (model_done) begin done_cyc = cyc; got_done = 1'b1; end
      if (res_valid && !prev_rv)
        chk("res_valid_latency", cyc, got_done ? done_cyc + 2 : start_cyc + TO + 2);
      if (prev_hs) begin
        chk("res_valid_drop", {31'd0, res_valid}, 0);
        chk("idle_op_ready", {31'd0, op_ready}, 1);
      end
      if (res_valid && prev_rv && !prev_rr) begin
        chk("hold_result", {16'd0, result}, {16'd0, prev_res});
        chk("hold_res_err", {31'd0, res_err}, {31'd0, prev_err});
        chk("hold_op_ready", {31'd0, op_ready}, 0);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          chk("result", {16'd0, result}, {16'd0, exp_v[15:0]});
          chk("res_err", {31'd0, res_err}, {31'd0, exp_v[16]});
        end
      end
      prev_start = start; prev_rv = res_valid; prev_rr = res_ready;
      prev_hs = res_valid && res_ready; prev_res = result; prev_err = res_err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [16:0] exp, input bit push);
    int n = 0;
    op_a = a; op_b = b; op_valid = 1'b1;
    @(negedge clk);
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      chk("accept_timeout", 0, 1);
      op_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, n < 300}, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_res_valid();
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_timeout", {31'd0, res_valid}, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_a = 1'b1; op_valid = 1'b0; op_a = 8'h0; op_b = 8'h0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", {31'd0, op_ready}, 1);
    chk("rst_start", {31'd0, start}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_err", {31'd0, res_err}, 0);
    chk("rst_result", {16'd0, result}, 0);
    chk("rst_dataa", {24'd0, dataa}, 0);
    chk("rst_datab", {24'd0, datab}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_proto_err", {31'd0, proto_err}, 0);
    @(posedge clk); #1;
    reset_a = 1'b0;

    // Basic: 0x0F * 0x0A, done 5 cycles after start.
    mult_lat = 5;
    send_op(8'h0F, 8'h0A, {1'b0, 16'h0096}, 1'b1);
    op_valid = 1'b0;
    drain();

    // Max operands.
    send_op(8'hFF, 8'hFF, {1'b0, 16'hFE01}, 1'b1);
    op_valid = 1'b0;
    drain();

    // Backpressure: res_ready low for three HOLD cycles.
    res_ready = 1'b0;
    send_op(8'h12, 8'h34, {1'b0, 16'h03A8}, 1'b1);
    op_valid = 1'b0;
    wait_res_valid();
    chk("bp_result", {16'd0, result}, 32'h03A8);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_res_valid", {31'd0, res_valid}, 1);
      chk("bp_op_ready", {31'd0, op_ready}, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    drain();

    // Timeout: multiplier never answers.
    never_done = 1'b1;
    send_op(8'h55, 8'h02, {1'b1, 16'h0000}, 1'b1);
    op_valid = 1'b0;
    drain();
    never_done = 1'b0;

    // Reset in the second WAIT cycle; transaction is discarded.
    send_op(8'h07, 8'h09, 17'h0, 1'b0);
    op_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_a = 1'b1;
    @(posedge clk); #1;
    reset_a = 1'b0;
    @(negedge clk);
    chk("midrst_op_ready", {31'd0, op_ready}, 1);
    chk("midrst_start", {31'd0, start}, 0);
    chk("midrst_res_valid", {31'd0, res_valid}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;
    send_op(8'h03, 8'h04, {1'b0, 16'h000C}, 1'b1);
    op_valid = 1'b0;
    drain();

    // Spurious done in IDLE sets the sticky protocol error.
    chk("proto_clear_before", {31'd0, proto_err}, 0);
    force_done = 1'b1;
    @(posedge clk); #1;
    force_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("proto_set", {31'd0, proto_err}, 1);
      chk("proto_no_result", {31'd0, res_valid}, 0);
    end
    @(posedge clk); #1;

    // Back-to-back with op_valid held high.
    mult_lat  = 3;
    b2b_phase = 1'b1;
    send_op(8'h05, 8'h06, {1'b0, 16'h001E}, 1'b1);
    send_op(8'h10, 8'h10, {1'b0, 16'h0100}, 1'b1);
    op_valid = 1'b0;
    drain();
    b2b_phase = 1'b0;
    chk("b2b_both_started", {31'd0, b2b_seen}, 1);
    chk("proto_sticky", {31'd0, proto_err}, 1);

    // Only reset clears the protocol error.
    reset_a = 1'b1;
    @(posedge clk); #1;
    reset_a = 1'b0;
    @(negedge clk);
    chk("proto_reset_clear", {31'd0, proto_err}, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mult_seq_driver
